// File: rtl/simon_seq_engine_if.sv
// simon_seq_engine_if
//   Bundles the player-side controls and the display/status outputs of the
//   Simon sequence engine so they travel as one port.
//
//   There are no valid/ready pairs on this bus. Every control input is a
//   plain level signal. The engine registers each one and acts only on its
//   rising edge, so a held button counts as a single press.
//
//   Signals
//     level     [1:0]  target length select, sampled when a game starts
//     mode             0 = Simon (machine colours), 1 = Build (player colours)
//     start            start request (rising edge)
//     replay           replay the current sequence (rising edge)
//     btn       [3:0]  colour buttons [0]=red [1]=blue [2]=yellow [3]=green
//     led_rgb   [2:0]  active-low {R,G,B} indicator
//     busy             high while a game is running
//     win, lose        end-of-game flags
//     score     [SW-1:0] longest sequence reproduced in the current game
//     state_dbg [3:0]  current FSM state encoding
//
//   Modports
//     master : the player side (drives the controls, watches the outputs)
//     slave  : the engine
interface simon_seq_engine_if #(
    parameter int MAX_LEN = 32
);
    localparam int SW = $clog2(MAX_LEN + 1);

    logic [1:0]    level;
    logic          mode;
    logic          start;
    logic          replay;
    logic [3:0]    btn;
    logic [2:0]    led_rgb;
    logic          busy;
    logic          win;
    logic          lose;
    logic [SW-1:0] score;
    logic [3:0]    state_dbg;

    modport master (
        output level, mode, start, replay, btn,
        input  led_rgb, busy, win, lose, score, state_dbg
    );

    modport slave (
        input  level, mode, start, replay, btn,
        output led_rgb, busy, win, lose, score, state_dbg
    );
endinterface

// File: rtl/simon_seq_engine.sv
// simon_seq_engine
//   Sequence engine for a Simon-style memory game. In Simon mode the engine
//   grows a random colour sequence one colour per round. In Build mode the
//   player appends colours and must reproduce the sequence each time.
//   Playback is a cyan cue followed by each colour lit, with dark gaps
//   between colours.
//
//   Ports
//     clock  : single clock, rising edge
//     reset  : asynchronous active-low reset
//     bus    : simon_seq_engine_if.slave (controls, LED, status, score, state)
module simon_seq_engine #(
    parameter int          MAX_LEN       = 32,
    parameter int          SHOW_TICKS    = 100,
    parameter int          GAP_TICKS     = 50,
    parameter int          TIMEOUT_TICKS = 500000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    simon_seq_engine_if.slave bus
);
    localparam int SW     = $clog2(MAX_LEN + 1);
    localparam int AW     = $clog2(MAX_LEN);
    localparam int TMAX_A = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TMAX   = (TIMEOUT_TICKS > TMAX_A) ? TIMEOUT_TICKS : TMAX_A;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [SW-1:0] LEN_MAX = SW'(MAX_LEN);
    localparam logic [SW-1:0] LEN_Q1  = SW'(MAX_LEN / 4);
    localparam logic [SW-1:0] LEN_Q2  = SW'(MAX_LEN / 2);
    localparam logic [SW-1:0] LEN_Q3  = SW'((3 * MAX_LEN) / 4);

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

    localparam logic [2:0] LED_OFF     = 3'b111;
    localparam logic [2:0] LED_CYAN    = 3'b100;
    localparam logic [2:0] LED_MAGENTA = 3'b010;
    localparam logic [2:0] LED_WHITE   = 3'b000;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CONFIG  = 4'd1,
        S_CUE     = 4'd2,
        S_SHOW    = 4'd3,
        S_GAP     = 4'd4,
        S_WAIT_IN = 4'd5,
        S_CHECK   = 4'd6,
        S_BUILD   = 4'd7,
        S_WIN     = 4'd8,
        S_LOSE    = 4'd9
    } state_t;

    state_t state, state_n;

    // Input registers and one-cycle edge history.
    logic [1:0] level_r;
    logic       mode_r;
    logic       start_r, start_p;
    logic       replay_r, replay_p;
    logic [3:0] btn_r, btn_p;

    logic [15:0]   lfsr;
    logic          mode_q;
    logic [SW-1:0] target;
    logic [SW-1:0] n;
    logic [SW-1:0] idx;
    logic [SW-1:0] score_q;
    logic [TW-1:0] cnt;
    logic [1:0]    press_col;

    logic [1:0] seq [MAX_LEN];
    logic       seq_we;
    logic [AW-1:0] seq_wa;
    logic [1:0] seq_wd;

    logic       start_e, replay_e, any_btn;
    logic [3:0] btn_e;
    logic [1:0] btn_col;
    logic [1:0] cur_col;
    logic [SW-1:0] n_m1;
    logic       last_idx, match, gap_done, show_done, tmo_done, replay_ok;
    logic [SW-1:0] lvl_target;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_r  <= '0;
            mode_r   <= 1'b0;
            start_r  <= 1'b0;
            start_p  <= 1'b0;
            replay_r <= 1'b0;
            replay_p <= 1'b0;
            btn_r    <= '0;
            btn_p    <= '0;
        end else begin
            level_r  <= bus.level;
            mode_r   <= bus.mode;
            start_r  <= bus.start;
            start_p  <= start_r;
            replay_r <= bus.replay;
            replay_p <= replay_r;
            btn_r    <= bus.btn;
            btn_p    <= btn_r;
        end
    end

    assign start_e  = start_r & ~start_p;
    assign replay_e = replay_r & ~replay_p;
    assign btn_e    = btn_r & ~btn_p;
    assign any_btn  = |btn_e;

    // Simultaneous presses resolve to the lowest button index.
    always_comb begin
        btn_col = 2'd0;
        if (btn_e[0])      btn_col = 2'd0;
        else if (btn_e[1]) btn_col = 2'd1;
        else if (btn_e[2]) btn_col = 2'd2;
        else if (btn_e[3]) btn_col = 2'd3;
    end

    // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1. Only reset clears it,
    // so successive games draw different colours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb begin
        case (level_r)
            2'b00:   lvl_target = LEN_Q1;
            2'b01:   lvl_target = LEN_Q2;
            2'b10:   lvl_target = LEN_Q3;
            default: lvl_target = LEN_MAX;
        endcase
    end

    // idx doubles as the playback pointer and the input-check pointer.
    assign cur_col   = seq[idx[AW-1:0]];
    assign n_m1      = n - SW'(1);
    assign last_idx  = (idx == n_m1);
    assign match     = (press_col == cur_col);
    assign gap_done  = (cnt == GAP_LAST);
    assign show_done = (cnt == SHOW_LAST);
    assign tmo_done  = (cnt == TMO_LAST);
    assign replay_ok = replay_e && (idx == '0);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_WIN, S_LOSE: if (start_e) state_n = S_CONFIG;
            S_CONFIG:  state_n = mode_r ? S_BUILD : S_CUE;
            S_CUE:     if (gap_done) state_n = (n == '0) ? S_BUILD : S_SHOW;
            S_SHOW:    if (show_done) state_n = S_GAP;
            S_GAP:     if (gap_done) state_n = last_idx ? S_WAIT_IN : S_SHOW;
            S_WAIT_IN: begin
                if (any_btn)        state_n = S_CHECK;
                else if (replay_ok) state_n = S_CUE;
                else if (tmo_done)  state_n = S_LOSE;
            end
            S_CHECK: begin
                if (!match)            state_n = S_LOSE;
                else if (!last_idx)    state_n = S_WAIT_IN;
                else if (mode_q)       state_n = S_BUILD;
                else if (n == target)  state_n = S_WIN;
                else                   state_n = S_CUE;
            end
            S_BUILD: begin
                if (any_btn)        state_n = (n == LEN_MAX - SW'(1)) ? S_WIN : S_WAIT_IN;
                else if (replay_ok) state_n = S_CUE;
                else if (tmo_done)  state_n = S_LOSE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Game datapath: lengths, pointers, tick counter, score.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q    <= 1'b0;
            target    <= '0;
            n         <= '0;
            idx       <= '0;
            score_q   <= '0;
            cnt       <= '0;
            press_col <= '0;
        end else begin
            case (state)
                S_CONFIG: begin
                    mode_q  <= mode_r;
                    target  <= mode_r ? LEN_MAX : lvl_target;
                    n       <= mode_r ? '0 : SW'(1);
                    idx     <= '0;
                    score_q <= '0;
                    cnt     <= '0;
                end
                S_CUE, S_SHOW: begin
                    if ((state == S_CUE && gap_done) || (state == S_SHOW && show_done))
                        cnt <= '0;
                    else
                        cnt <= cnt + TW'(1);
                end
                S_GAP: begin
                    if (gap_done) begin
                        cnt <= '0;
                        idx <= last_idx ? '0 : idx + SW'(1);
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                S_WAIT_IN: begin
                    if (any_btn) begin
                        press_col <= btn_col;
                        cnt       <= '0;
                    end else if (replay_ok) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (match) begin
                        if (!last_idx) begin
                            idx <= idx + SW'(1);
                        end else begin
                            score_q <= n;
                            idx     <= '0;
                            if (!mode_q && n != target) n <= n + SW'(1);
                        end
                    end
                end
                S_BUILD: begin
                    if (any_btn) begin
                        n   <= n + SW'(1);
                        idx <= '0;
                        cnt <= '0;
                    end else if (replay_ok) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Sequence memory write port; index MAX_LEN is never written.
    always_comb begin
        seq_we = 1'b0;
        seq_wa = n[AW-1:0];
        seq_wd = lfsr[1:0];
        case (state)
            S_CONFIG: if (!mode_r) begin
                seq_we = 1'b1;
                seq_wa = '0;
            end
            S_CHECK: if (match && last_idx && !mode_q && n != target && n < LEN_MAX)
                seq_we = 1'b1;
            S_BUILD: if (any_btn && n < LEN_MAX) begin
                seq_we = 1'b1;
                seq_wd = btn_col;
            end
            default: seq_we = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (seq_we) seq[seq_wa] <= seq_wd;
    end

    // Outputs.
    always_comb begin
        bus.led_rgb = LED_OFF;
        case (state)
            S_CUE:  bus.led_rgb = LED_CYAN;
            S_SHOW: begin
                case (cur_col)
                    2'd0:    bus.led_rgb = 3'b011;
                    2'd1:    bus.led_rgb = 3'b110;
                    2'd2:    bus.led_rgb = 3'b001;
                    default: bus.led_rgb = 3'b101;
                endcase
            end
            S_WIN:   bus.led_rgb = LED_WHITE;
            S_LOSE:  bus.led_rgb = LED_MAGENTA;
            default: bus.led_rgb = LED_OFF;
        endcase
        bus.busy      = !(state == S_IDLE || state == S_WIN || state == S_LOSE);
        bus.win       = (state == S_WIN);
        bus.lose      = (state == S_LOSE);
        bus.score     = score_q;
        bus.state_dbg = state;
    end
endmodule

// File: tb/tb_simon_seq_engine.sv
`timescale 1ns/1ps
module tb_simon_seq_engine;
    localparam int MAX_LEN       = 8;
    localparam int SHOW_TICKS    = 4;
    localparam int GAP_TICKS     = 2;
    localparam int TIMEOUT_TICKS = 20;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SHOW    = 4'd3;
    localparam logic [3:0] S_WAIT_IN = 4'd5;
    localparam logic [3:0] S_BUILD   = 4'd7;

    localparam logic [2:0] LED_OFF     = 3'b111;
    localparam logic [2:0] LED_CYAN    = 3'b100;
    localparam logic [2:0] LED_RED     = 3'b011;
    localparam logic [2:0] LED_BLUE    = 3'b110;
    localparam logic [2:0] LED_YELLOW  = 3'b001;
    localparam logic [2:0] LED_GREEN   = 3'b101;
    localparam logic [2:0] LED_WHITE   = 3'b000;
    localparam logic [2:0] LED_MAGENTA = 3'b010;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   shown[$];
    logic [2:0] exp_q[$];

    simon_seq_engine_if #(.MAX_LEN(MAX_LEN)) bus ();

    simon_seq_engine #(
        .MAX_LEN(MAX_LEN),
        .SHOW_TICKS(SHOW_TICKS),
        .GAP_TICKS(GAP_TICKS),
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Driver tasks (all driving happens at the falling edge)
    task automatic step(input int k);
        repeat (k) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] b);
        bus.btn = b;
        step(1);
        bus.btn = 4'b0000;
        step(3);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic pulse_replay();
        bus.replay = 1'b1;
        step(1);
        bus.replay = 1'b0;
    endtask

    function automatic int col_of(input logic [2:0] led);
        case (led)
            LED_RED:    return 0;
            LED_BLUE:   return 1;
            LED_YELLOW: return 2;
            LED_GREEN:  return 3;
            default:    return -1;
        endcase
    endfunction

    task automatic wait_state(input logic [3:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state_dbg == s) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    // Records the colours lit during a playback until the engine waits for input.
    task automatic play_round(output bit ok);
        logic [3:0] prev;
        prev = bus.state_dbg;
        shown.delete();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (bus.state_dbg == S_SHOW && prev != S_SHOW) shown.push_back(col_of(bus.led_rgb));
            if (bus.state_dbg == S_WAIT_IN && shown.size() > 0) begin
                ok = 1'b1;
                break;
            end
            prev = bus.state_dbg;
        end
    endtask

    task automatic echo_shown();
        logic [3:0] b;
        for (int i = 0; i < shown.size(); i++) begin
            check("shown_colour_valid", 32'(shown[i] >= 0), 1);
            b = 4'b0001 << shown[i][1:0];
            press(b);
        end
    endtask

    initial begin
        bit ok;
        int r1_col;
        logic [2:0] e;
        logic [3:0] wrong;

        bus.level  = 2'b00;
        bus.mode   = 1'b0;
        bus.start  = 1'b0;
        bus.replay = 1'b0;
        bus.btn    = 4'b0000;

        // Reset values
        step(3);
        check("rst_led", bus.led_rgb, LED_OFF);
        check("rst_busy", bus.busy, 0);
        check("rst_win", bus.win, 0);
        check("rst_lose", bus.lose, 0);
        check("rst_score", bus.score, 0);
        check("rst_state", bus.state_dbg, S_IDLE);
        reset = 1'b1;

        // Idle for 100 cycles with no stimulus
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("idle_led", bus.led_rgb, LED_OFF);
            check("idle_busy", bus.busy, 0);
            check("idle_score", bus.score, 0);
        end

        // Simon, level 00 (target 2), echo every shown colour
        bus.level = 2'b00;
        bus.mode  = 1'b0;
        pulse_start();
        play_round(ok);
        check("s1_round1_reached", ok, 1);
        check("s1_round1_len", shown.size(), 1);
        r1_col = shown[0];
        check("s1_busy", bus.busy, 1);
        echo_shown();
        check("s1_score_after_r1", bus.score, 1);
        check("s1_no_win_yet", bus.win, 0);
        play_round(ok);
        check("s1_round2_reached", ok, 1);
        check("s1_round2_len", shown.size(), 2);
        check("s1_round2_first", shown[0], r1_col);
        echo_shown();
        check("s1_win", bus.win, 1);
        check("s1_win_led", bus.led_rgb, LED_WHITE);
        check("s1_win_score", bus.score, 2);
        check("s1_win_busy", bus.busy, 0);
        check("s1_win_lose", bus.lose, 0);

        // Simon, level 01, wrong colour in round 1
        bus.level = 2'b01;
        pulse_start();
        play_round(ok);
        check("s2_round1_reached", ok, 1);
        check("s2_win_cleared", bus.win, 0);
        wrong = 4'b0001 << ((shown[0] + 1) % 4);
        press(wrong);
        check("s2_lose", bus.lose, 1);
        check("s2_lose_led", bus.led_rgb, LED_MAGENTA);
        check("s2_lose_score", bus.score, 0);
        check("s2_lose_win", bus.win, 0);

        // Simon, no press in WAIT_IN -> timeout
        pulse_start();
        play_round(ok);
        check("s3_round1_reached", ok, 1);
        check("s3_lose_cleared", bus.lose, 0);
        step(17);
        check("s3_before_timeout_lose", bus.lose, 0);
        check("s3_before_timeout_state", bus.state_dbg, S_WAIT_IN);
        step(5);
        check("s3_timeout_lose", bus.lose, 1);
        check("s3_timeout_led", bus.led_rgb, LED_MAGENTA);

        // Build mode: red / red,blue / red,blue,green
        bus.mode = 1'b1;
        pulse_start();
        wait_state(S_BUILD, 10, ok);
        check("b_enter_build", ok, 1);
        check("b_score0", bus.score, 0);
        check("b_lose_cleared", bus.lose, 0);
        press(4'b0001);
        check("b_add_red_state", bus.state_dbg, S_WAIT_IN);
        press(4'b0001);
        check("b_rep1_state", bus.state_dbg, S_BUILD);
        check("b_rep1_score", bus.score, 1);
        press(4'b0010);
        check("b_add_blue_state", bus.state_dbg, S_WAIT_IN);
        press(4'b0001);
        press(4'b0010);
        check("b_rep2_state", bus.state_dbg, S_BUILD);
        check("b_rep2_score", bus.score, 2);
        press(4'b1000);
        check("b_add_green_state", bus.state_dbg, S_WAIT_IN);
        check("b_add_green_score", bus.score, 2);

        // Start edge mid-game is ignored
        pulse_start();
        step(2);
        check("b_start_ignored_state", bus.state_dbg, S_WAIT_IN);
        check("b_start_ignored_score", bus.score, 2);

        // Replay: cue, then red, blue, green each lit SHOW_TICKS cycles
        for (int i = 0; i < GAP_TICKS; i++) exp_q.push_back(LED_CYAN);
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < SHOW_TICKS; i++)
                exp_q.push_back(c == 0 ? LED_RED : (c == 1 ? LED_BLUE : LED_GREEN));
            for (int i = 0; i < GAP_TICKS; i++) exp_q.push_back(LED_OFF);
        end
        exp_q.push_back(LED_OFF);
        pulse_replay();
        while (exp_q.size() > 0) begin
            step(1);
            e = exp_q.pop_front();
            check("b_replay_led", bus.led_rgb, e);
        end
        check("b_replay_back_wait", bus.state_dbg, S_WAIT_IN);

        // Red and green together: red wins and matches seq[0]
        press(4'b1001);
        check("b_multi_press_state", bus.state_dbg, S_WAIT_IN);
        check("b_multi_press_lose", bus.lose, 0);

        // Replay at idx=1 is ignored
        pulse_replay();
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("b_replay_ignored_state", bus.state_dbg, S_WAIT_IN);
            check("b_replay_ignored_led", bus.led_rgb, LED_OFF);
        end
        press(4'b0010);
        press(4'b1000);
        check("b_rep3_state", bus.state_dbg, S_BUILD);
        check("b_rep3_score", bus.score, 3);

        // Timeout in BUILD
        step(14);
        check("b_build_wait_lose", bus.lose, 0);
        step(8);
        check("b_build_timeout_lose", bus.lose, 1);

        // Reset during SHOW, then a fresh game
        bus.mode  = 1'b0;
        bus.level = 2'b11;
        pulse_start();
        wait_state(S_SHOW, 20, ok);
        check("r_reach_show", ok, 1);
        reset = 1'b0;
        #1;
        check("r_async_led", bus.led_rgb, LED_OFF);
        check("r_async_busy", bus.busy, 0);
        check("r_async_state", bus.state_dbg, S_IDLE);
        check("r_async_score", bus.score, 0);
        step(2);
        reset = 1'b1;
        step(5);
        check("r_idle_after_release", bus.state_dbg, S_IDLE);
        check("r_idle_led", bus.led_rgb, LED_OFF);
        pulse_start();
        step(2);
        check("r_new_game_busy", bus.busy, 1);
        check("r_new_game_score", bus.score, 0);
        check("r_new_game_cue", bus.led_rgb, LED_CYAN);
        play_round(ok);
        check("r_new_round_reached", ok, 1);
        check("r_new_round_len", shown.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/simon_seq_engine.md
SIMON_SEQ_ENGINE -- requirements
Module: simon_seq_engine

Interface
REQ-001 Parameter MAX_LEN, default 32: sequence memory depth in colours; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter SHOW_TICKS, default 100: clock cycles one colour is lit during playback.
REQ-003 Parameter GAP_TICKS, default 50: clock cycles of cue and inter-colour dark gap.
REQ-004 Parameter TIMEOUT_TICKS, default 500000: clock cycles allowed between player presses.
REQ-005 Parameter LFSR_SEED, default 16'hACE1: reset value of the 16-bit colour LFSR; SHALL be non-zero.
REQ-006 clock  in  1  single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 level  in  2  target length select, sampled in CONFIG.
REQ-009 mode  in  1  0 = Simon (machine-generated), 1 = Build (player-generated), sampled in CONFIG.
REQ-010 start  in  1  start request, rising-edge detected.
REQ-011 replay  in  1  replay current sequence, rising-edge detected.
REQ-012 btn  in  4  colour buttons, [0]=red [1]=blue [2]=yellow [3]=green, rising-edge detected.
REQ-013 led_rgb  out  3  active-low {R,G,B}: red 011, blue 110, yellow 001, green 101, cyan 100, magenta 010, white 000, off 111.
REQ-014 busy  out  1  high in every state except IDLE, WIN and LOSE.
REQ-015 win, lose  out  1 each  end-of-game flags, held until the next CONFIG.
REQ-016 score  out  $clog2(MAX_LEN+1)  length of the longest sequence reproduced correctly in the current game.

Function
REQ-017 All inputs SHALL be registered once; an edge is the registered value at 1 while the previous registered value was 0. Edge detection adds 1 cycle of latency.
REQ-018 When more than one btn edge occurs in the same cycle, the lowest index SHALL win: red > blue > yellow > green.
REQ-019 The LFSR SHALL use taps x^16+x^14+x^13+x^11+1, advance every cycle, and never be reset by start.
REQ-020 States: IDLE, CONFIG, CUE, SHOW, GAP, WAIT_IN, CHECK, BUILD, WIN, LOSE.
REQ-021 A start edge in IDLE, WIN or LOSE SHALL enter CONFIG; a start edge in any other state SHALL be ignored.
REQ-022 CONFIG lasts 1 cycle. It latches mode, clears score, win, lose, and the index, and sets the target length: level 00=MAX_LEN/4, 01=MAX_LEN/2, 10=3*MAX_LEN/4, 11=MAX_LEN. Build mode always uses target MAX_LEN.
REQ-023 In Simon mode, CONFIG SHALL store lfsr[1:0] as seq[0], set length n=1, then go to CUE. In Build mode it SHALL set n=0 and go to BUILD.
REQ-024 CUE shows cyan for GAP_TICKS cycles. For each i=0..n-1, SHOW displays seq[i] for SHOW_TICKS cycles, then GAP shows off for GAP_TICKS cycles. After the last gap the block enters WAIT_IN with idx=0.
REQ-025 WAIT_IN and BUILD show off. Each SHALL count up to TIMEOUT_TICKS; reaching it SHALL enter LOSE. The count restarts on every accepted press.
REQ-026 A btn edge in WAIT_IN SHALL enter CHECK. CHECK lasts 1 cycle and SHALL compare the pressed colour against seq[idx]:
- mismatch: go to LOSE.
- match with idx<n-1: idx+1, return to WAIT_IN.
- match with idx=n-1: score=n, then:
  - Simon with n=target: go to WIN.
  - Simon otherwise: seq[n]=lfsr[1:0], n+1, go to CUE.
  - Build: go to BUILD.
REQ-027 In BUILD, a btn edge SHALL write the colour to seq[n] and set n+1. If n reaches MAX_LEN the block goes to WIN; otherwise it goes to WAIT_IN with idx=0 and no playback.
REQ-028 A replay edge in WAIT_IN or BUILD with idx=0 SHALL enter CUE and replay seq[0..n-1], then return to WAIT_IN (or BUILD if n=0) with the timeout count cleared. With idx>0 the replay edge SHALL be ignored.
REQ-029 WIN SHALL show white with win=1; LOSE SHALL show magenta with lose=1. Both hold until a start edge.
REQ-030 Sequence memory SHALL be MAX_LEN x 2 bits, written only in CONFIG, CHECK and BUILD. No write is permitted at index MAX_LEN.

Reset
REQ-031 While reset=0, the block SHALL immediately enter IDLE with led_rgb=111, busy=0, win=0, lose=0, score=0, n=0, idx=0, all counters 0, edge-history registers 0, and lfsr=LFSR_SEED.
REQ-032 Reset asserted mid-game SHALL abandon the game; after release the block SHALL remain in IDLE until a start edge.

Verification (MAX_LEN=8, SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20)
REQ-033 Reset release, no stimulus for 100 cycles -> led_rgb=111, busy=0, score=0 throughout.
REQ-034 Simon, level=00, start, then echo every shown colour -> rounds of length 1 and 2 played; after the second correct CHECK, win=1, led_rgb=000, score=2.
REQ-035 Simon, level=01, one wrong colour in round 1 -> lose=1, led_rgb=010, score=0. No press for 20 cycles in WAIT_IN -> lose=1.
REQ-036 Build mode, presses red, then red,blue, then red,blue,green -> n=3, score=2. A subsequent replay edge -> cue plus red, blue, green each lit 4 cycles.
REQ-037 Red and green edges in the same cycle, with seq[idx]=red -> accepted as correct. Replay edge at idx=1 -> ignored.
REQ-038 reset=0 during SHOW -> led_rgb=111 within the same cycle. A start edge after release -> new game with score=0.
